drs_trig_ctrl: RTL
==================

DRS_TRIG_CTRL -- requirements
Module: drs_trig_ctrl

Interface
REQ-001 Parameter: READ_TIMEOUT_CYC, default 20'd200000, is the maximum number of cycles spent in READ before the read is aborted.
REQ-002 Parameter: LOST_CNT_W, default 16, is the width of the lost-trigger counter.
REQ-003 Port CLK, input, 1 bit, is the single clock; every register is clocked on its rising edge.
REQ-004 Port RST, input, 1 bit, is the reset: synchronous and active-high.
REQ-005 Port TRIG_IN, input, 1 bit, is the level trigger, already synchronous to CLK; its rising edge is an event request.
REQ-006 Port TRIG_ENABLE, input, 1 bit: when low, the block ignores all triggers.
REQ-007 Port DFIFO_PROGFULL, input, 1 bit, is the programmable-full flag of the readout FIFO.
REQ-008 Port STOP_DELAY, input, 8 bits, is the number of cycles between domino stop and the read command.
REQ-009 Port DEADTIME, input, 16 bits, is the minimum number of idle cycles after a read.
REQ-010 Port DRS_READ_DONE, input, 1 bit, is the done flag from the readout sequencer.
REQ-011 Port DRS_STATE_COM, output, 4 bits, is the command to the readout sequencer.
REQ-012 Port DRS_DWRITE, output, 1 bit, is the domino write enable; 1 means sampling.
REQ-013 Port BUSY, output, 1 bit, is high whenever the state is not IDLE.
REQ-014 Port EVENT_COUNT, output, 32 bits, is the count of accepted triggers.
REQ-015 Port TRIG_LOST, output, LOST_CNT_W bits, is the count of rejected triggers.
REQ-016 Port RD_TIMEOUT, output, 1 bit, is a sticky flag for a read that timed out.

Function
REQ-017 The block SHALL detect trigger edges by registering TRIG_IN (trig_d) and forming edge = TRIG_IN & ~trig_d.
REQ-018 The FSM SHALL have the states IDLE, STOP, READ, FINISH and DEAD; all outputs are registered.
REQ-019 Outputs per state SHALL be:
- IDLE: DRS_STATE_COM=0, DRS_DWRITE=1.
- STOP: DRS_STATE_COM=4, DRS_DWRITE=0.
- READ: DRS_STATE_COM=5, DRS_DWRITE=0.
- FINISH: DRS_STATE_COM=6, DRS_DWRITE=0.
- DEAD: DRS_STATE_COM=0, DRS_DWRITE=1.
REQ-020 A trigger SHALL be accepted in IDLE when edge & TRIG_ENABLE & ~DFIFO_PROGFULL.
- On acceptance: go to STOP, load the delay counter with STOP_DELAY, and increment EVENT_COUNT (mod 2^32).
REQ-021 A trigger SHALL be rejected when edge & TRIG_ENABLE and the block is either not in IDLE or DFIFO_PROGFULL=1.
- On rejection: increment TRIG_LOST, saturating at all-ones.
- Edges seen while TRIG_ENABLE=0 are neither accepted nor counted.
REQ-022 In STOP, the block SHALL count the delay counter down and enter READ in the cycle after it reaches 0.
- STOP therefore lasts STOP_DELAY+1 cycles; STOP_DELAY=0 gives 1 cycle.
REQ-023 On entering READ, the block SHALL clear the timeout counter (20 bits).
- Each READ cycle increments it.
- DRS_READ_DONE=1 moves the FSM to FINISH.
- If the counter reaches READ_TIMEOUT_CYC-1 without done, the FSM moves to FINISH and RD_TIMEOUT is set.
- If done and timeout occur in the same cycle, done wins and RD_TIMEOUT is not set.
REQ-024 In FINISH, the block SHALL move to DEAD in the cycle after DRS_READ_DONE is sampled low, and load the dead counter with DEADTIME.
REQ-025 In DEAD, the block SHALL count down and enter IDLE in the cycle after the counter reaches 0.
- DEAD therefore lasts DEADTIME+1 cycles.
REQ-026 A trigger edge that arrives in the same cycle that DEAD transitions to IDLE SHALL be rejected and counted as lost.
REQ-027 DFIFO_PROGFULL SHALL be evaluated only at acceptance; if it rises mid-event, the current event still completes.
REQ-028 RD_TIMEOUT SHALL be cleared only by RST.
REQ-029 BUSY SHALL be registered together with the state, so it goes high in the cycle STOP is entered.

Reset
REQ-030 While RST=1 at a clock edge, the block SHALL load the following values at that edge:
- state=IDLE, DRS_STATE_COM=0, DRS_DWRITE=1, BUSY=0;
- EVENT_COUNT=0, TRIG_LOST=0, RD_TIMEOUT=0;
- all internal counters=0, trig_d=0.
REQ-031 RST asserted in any state, including mid-READ, SHALL return the block to IDLE with the values of REQ-030 on the next edge, without passing through FINISH or DEAD.
REQ-032 An edge on TRIG_IN in the first cycle after reset release SHALL be detected normally, because trig_d was reset to 0.

Verification
REQ-033 Nominal event, with STOP_DELAY=3 and DEADTIME=10, done pulled high 50 cycles after READ is entered and cleared when COM=6 is seen:
- STOP lasts 4 cycles.
- DRS_STATE_COM runs 4, 5, 6, 0.
- DEAD lasts 11 cycles.
- EVENT_COUNT=1 and BUSY returns to 0.
REQ-034 Progfull: with DFIFO_PROGFULL=1 and 3 trigger edges in IDLE:
- FSM stays in IDLE, TRIG_LOST=3, EVENT_COUNT=0.
- After PROGFULL returns to 0, the next edge is accepted.
REQ-035 Busy rejection: 5 edges during READ give TRIG_LOST=5; with TRIG_ENABLE=0 the same stimulus gives TRIG_LOST unchanged.
REQ-036 Timeout: with READ_TIMEOUT_CYC=100 and done held low:
- FSM leaves READ after 100 cycles and RD_TIMEOUT=1.
- The next event completes normally with RD_TIMEOUT still 1.
REQ-037 Saturation and wrap:
- TRIG_LOST preloaded to 16'hFFFE plus 3 rejects reads 16'hFFFF.
- EVENT_COUNT preloaded to 32'hFFFFFFFF plus 1 accept reads 0.
REQ-038 Reset mid-READ: assert RST for 1 cycle; next cycle shows COM=0, DWRITE=1, BUSY=0 and all counters 0.

Source files
------------

// File: rtl/drs_trig_ctrl.sv
// DRS4 trigger controller: accepts trigger edges, sequences stop/read/finish
// commands to the readout sequencer, enforces dead time and counts lost triggers.
module drs_trig_ctrl #(
  parameter logic [19:0] READ_TIMEOUT_CYC = 20'd200000,
  parameter int          LOST_CNT_W       = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  TRIG_IN,
  input  logic                  TRIG_ENABLE,
  input  logic                  DFIFO_PROGFULL,
  input  logic [7:0]            STOP_DELAY,
  input  logic [15:0]           DEADTIME,
  input  logic                  DRS_READ_DONE,
  output logic [3:0]            DRS_STATE_COM,
  output logic                  DRS_DWRITE,
  output logic                  BUSY,
  output logic [31:0]           EVENT_COUNT,
  output logic [LOST_CNT_W-1:0] TRIG_LOST,
  output logic                  RD_TIMEOUT
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STOP   = 3'd1,
    ST_READ   = 3'd2,
    ST_FINISH = 3'd3,
    ST_DEAD   = 3'd4
  } state_t;

  state_t                state_r, state_s;
  logic                  trig_d_r;
  logic [7:0]            dly_r, dly_s;
  logic [19:0]           tmo_r, tmo_s;
  logic [15:0]           dead_r, dead_s;
  logic                  tmo_hit_s;
  logic [3:0]            com_r, com_s;
  logic                  dwrite_r, dwrite_s;
  logic                  busy_r, busy_s;
  logic [31:0]           event_count_r;
  logic [LOST_CNT_W-1:0] trig_lost_r;
  logic                  rd_timeout_r;
  logic                  edge_s, accept_s, reject_s;

  assign edge_s   = TRIG_IN & ~trig_d_r;
  assign accept_s = edge_s & TRIG_ENABLE & ~DFIFO_PROGFULL & (state_r == ST_IDLE);
  assign reject_s = edge_s & TRIG_ENABLE & (DFIFO_PROGFULL | (state_r != ST_IDLE));

  // State, counters and decoded outputs register together so BUSY tracks the state
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r  <= ST_IDLE;
      trig_d_r <= 1'b0;
      dly_r    <= 8'd0;
      tmo_r    <= 20'd0;
      dead_r   <= 16'd0;
      com_r    <= 4'd0;
      dwrite_r <= 1'b1;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      trig_d_r <= TRIG_IN;
      dly_r    <= dly_s;
      tmo_r    <= tmo_s;
      dead_r   <= dead_s;
      com_r    <= com_s;
      dwrite_r <= dwrite_s;
      busy_r   <= busy_s;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_s   = state_r;
    dly_s     = dly_r;
    tmo_s     = tmo_r;
    dead_s    = dead_r;
    tmo_hit_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_STOP;
          dly_s   = STOP_DELAY;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_STOP: begin
        if (dly_r == 8'd0) begin
          state_s = ST_READ;
          tmo_s   = 20'd0;
        end else begin
          dly_s = dly_r - 8'd1;
        end
      end
      ST_READ: begin
        tmo_s = tmo_r + 20'd1;
        // done takes priority over a coincident timeout
        if (DRS_READ_DONE) begin
          state_s = ST_FINISH;
        end else if (tmo_r == READ_TIMEOUT_CYC - 20'd1) begin
          state_s   = ST_FINISH;
          tmo_hit_s = 1'b1;
        end else begin
          state_s = ST_READ;
        end
      end
      ST_FINISH: begin
        if (!DRS_READ_DONE) begin
          state_s = ST_DEAD;
          dead_s  = DEADTIME;
        end else begin
          state_s = ST_FINISH;
        end
      end
      ST_DEAD: begin
        if (dead_r == 16'd0) begin
          state_s = ST_IDLE;
        end else begin
          dead_s = dead_r - 16'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output decode of the upcoming state
  always_comb begin
    com_s    = 4'd0;
    dwrite_s = 1'b1;
    busy_s   = 1'b1;
    case (state_s)
      ST_IDLE:   begin com_s = 4'd0; dwrite_s = 1'b1; busy_s = 1'b0; end
      ST_STOP:   begin com_s = 4'd4; dwrite_s = 1'b0; busy_s = 1'b1; end
      ST_READ:   begin com_s = 4'd5; dwrite_s = 1'b0; busy_s = 1'b1; end
      ST_FINISH: begin com_s = 4'd6; dwrite_s = 1'b0; busy_s = 1'b1; end
      ST_DEAD:   begin com_s = 4'd0; dwrite_s = 1'b1; busy_s = 1'b1; end
      default:   begin com_s = 4'd0; dwrite_s = 1'b1; busy_s = 1'b0; end
    endcase
  end

  // Event, lost-trigger and sticky timeout bookkeeping
  always_ff @(posedge CLK) begin
    if (RST) begin
      event_count_r <= 32'd0;
      trig_lost_r   <= {LOST_CNT_W{1'b0}};
      rd_timeout_r  <= 1'b0;
    end else begin
      if (accept_s) begin
        event_count_r <= event_count_r + 32'd1;
      end
      if (reject_s && (trig_lost_r != {LOST_CNT_W{1'b1}})) begin
        trig_lost_r <= trig_lost_r + LOST_CNT_W'(1);
      end
      rd_timeout_r <= rd_timeout_r | tmo_hit_s;
    end
  end

  assign DRS_STATE_COM = com_r;
  assign DRS_DWRITE    = dwrite_r;
  assign BUSY          = busy_r;
  assign EVENT_COUNT   = event_count_r;
  assign TRIG_LOST     = trig_lost_r;
  assign RD_TIMEOUT    = rd_timeout_r;

endmodule
